jslot_timer: RTL and testbench
==============================

# jslot_timer

Expansion-slot 24-bit programmable interval timer for the JRC-1 65816 system. Sits on a slot card and responds to one of the glue-logic slot selects (nSLOT1SEL/nSLOT2SEL/nSLOT3SEL), presenting 16 byte registers on the slot data bus. It raises a level-sensitive active-low IRQ on expiry. All logic runs on one fast clock; the 65816 bus strobes are sampled as data.

## Interface
- No parameters.
- CLK  input  1  system clock; frequency ≥ 4× PHI2; all state updates on rising edge.
- nRESET  input  1  asynchronous, active-low reset.
- PHI2  input  1  65816 bus phase clock, sampled as data and never used as a clock.
- nSEL  input  1  active-low slot select from glue logic.
- RWB  input  1  1 = CPU read, 0 = CPU write.
- A  input  4  register offset (A3..A0).
- D_IN  input  8  write data from CPU bus.
- D_OUT  output  8  read data to CPU bus.
- D_OE  output  1  drive enable for external data buffer.
- nIRQ  output  1  active-low interrupt request.

## Operation
- Bus commit: PHI2 passes a 2-flop synchronizer, then one more register for edge detect. A sync-PHI2 1→0 edge with nSEL low and the A/RWB/D_IN captured the previous cycle produces a one-CLK commit strobe. Writes and read side effects happen only on the commit strobe.
- A, RWB, nSEL and D_IN are captured every CLK while sync-PHI2 is high. The last values before the falling edge are committed.
- Read path: D_OE = ~nSEL & RWB & PHI2 (raw, combinational). D_OUT is a combinational mux of A over current register values. D_OUT = 0 when D_OE = 0.
- Register map:
  - 0 CTRL (r/w): bit0 EN, bit1 CONT (1 = auto-reload, 0 = one-shot), bit2 IRQEN. Bits 7..3 read 0.
  - 1 STATUS (r): bit0 EXP, bit1 = EN. A committed read clears EXP. Writes are ignored.
  - 2/3/4 RELOAD_LO/MID/HI (r/w). A write to HI commits: COUNT ← {HI, MID, LO} using the new HI value, and the prescaler clears.
  - 5 COUNT_LO (r): returns live COUNT[7:0]. A committed read latches COUNT[23:8] into SNAP.
  - 6/7 SNAP_MID/HI (r).
  - 8 PRESCALE (r/w): a tick occurs every PRESCALE+1 CLK cycles while EN = 1.
  - 9–15: read 0, writes ignored.
- Prescaler: 8-bit up-counter. It is held at 0 while EN = 0. When it equals PRESCALE it emits a tick and wraps to 0. A CTRL write with EN 0→1 clears it.
- Tick with COUNT ≠ 0: COUNT ← COUNT − 1.
- Tick with COUNT = 0:
  - EXP ← 1.
  - If CONT = 1: COUNT ← RELOAD.
  - If CONT = 0: EN ← 0 and COUNT stays at 0.
- RELOAD = 0 with CONT = 1 sets EXP on every tick.
- nIRQ = ~(EXP & IRQEN), registered. Clearing IRQEN deasserts nIRQ without clearing EXP.

## Timing
- Reset values:
  - CTRL = 0, STATUS = 0, RELOAD = 0, COUNT = 0, SNAP = 0, PRESCALE = 0, prescaler = 0, synchronizer = 0.
  - nIRQ = 1, D_OE = 0, D_OUT = 0.
- nRESET asserted mid-count or mid-bus-cycle: all state clears immediately. A commit pending in the edge detector is discarded.
- Commit latency: the write takes effect on the 3rd or 4th CLK after PHI2 falls. The written value is visible to the next bus cycle.
- Tick to EXP: EXP is set on the same edge that processes the zero tick. nIRQ falls one CLK later.
- Simultaneous events:
  - EXP set by a tick and clear by a STATUS read on the same CLK: set wins, EXP = 1.
  - Tick and RELOAD_HI commit on the same CLK: the commit wins, COUNT ← RELOAD, and the tick is dropped.
  - Tick and CTRL write on the same CLK: the written EN/CONT govern from the next CLK. The tick uses the old values.
- 24-bit COUNT decrement from 0 never underflows; COUNT = 0 is the expiry path.
- Reading COUNT_LO then MID/HI returns a coherent 24-bit value even while counting.

## Test plan
- Reset: assert nRESET mid-count -> nIRQ = 1, all registers read 0, D_OE = 0.
- One-shot:
  - Stimulus: PRESCALE = 0, RELOAD = 0x000003, CTRL = 0x05.
  - Required: EXP sets 4 CLK ticks after enable; nIRQ falls one CLK later; STATUS reads 0x01 (EN cleared); COUNT = 0.
- Continuous:
  - Stimulus: PRESCALE = 3, RELOAD = 0x000001, CTRL = 0x07.
  - Required: EXP sets every 8 CLK; a STATUS read clears EXP and nIRQ returns to 1; EXP sets again 8 CLK later.
- Snapshot coherence:
  - Stimulus: RELOAD = 0x010000, count running; read COUNT_LO at COUNT = 0x010000.
  - Required: SNAP MID/HI = 0x00/0x01 even after COUNT becomes 0x00FFFF.
- Collision: a STATUS read commit on the same CLK as an expiry tick -> EXP = 1 and nIRQ stays 0.
- Unmapped/deselected:
  - A write at offset 12 -> no register changes.
  - nSEL = 1 with RWB = 1 -> D_OE = 0, and no side effects from a COUNT_LO or STATUS access.

Source files
------------

// File: rtl/jslot_timer.sv
`timescale 1ns/1ps
// jslot_timer
// 24-bit programmable interval timer on a JRC-1 65816 expansion slot card.
// The 65816 bus strobes are sampled as data on CLK, and a register access is
// committed once, on the synchronized falling edge of PHI2.
//
// Ports
//   CLK     system clock, at least 4x PHI2
//   nRESET  asynchronous active-low reset
//   PHI2    65816 bus phase clock (sampled, never used as a clock)
//   nSEL    active-low slot select
//   RWB     1 = CPU read, 0 = CPU write
//   A       register offset
//   D_IN    CPU write data
//   D_OUT   CPU read data (0 while not driving)
//   D_OE    external data buffer drive enable
//   nIRQ    active-low level interrupt request (registered)
//
// Register map
//   0 CTRL      r/w  {5'b0, IRQEN, CONT, EN}
//   1 STATUS    r    {6'b0, EN, EXP}, a committed read clears EXP
//   2..4 RELOAD r/w  LO/MID/HI, a HI write also loads COUNT
//   5 COUNT_LO  r    live COUNT[7:0], a committed read latches COUNT[23:8]
//   6..7 SNAP   r    latched COUNT[15:8] / COUNT[23:16]
//   8 PRESCALE  r/w  tick every PRESCALE+1 CLK cycles
//   9..15            read 0, writes ignored
module jslot_timer (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PHI2,
    input  logic       nSEL,
    input  logic       RWB,
    input  logic [3:0] A,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       nIRQ
);

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_STATUS   = 4'd1;
    localparam logic [3:0] ADDR_REL_LO   = 4'd2;
    localparam logic [3:0] ADDR_REL_MID  = 4'd3;
    localparam logic [3:0] ADDR_REL_HI   = 4'd4;
    localparam logic [3:0] ADDR_COUNT_LO = 4'd5;
    localparam logic [3:0] ADDR_SNAP_MID = 4'd6;
    localparam logic [3:0] ADDR_SNAP_HI  = 4'd7;
    localparam logic [3:0] ADDR_PRESCALE = 4'd8;

    // PHI2 synchronizer: [0],[1] form the 2-flop synchronizer, [2] is the
    // delayed copy used for falling-edge detection.
    logic [2:0]  phi2_pipe;
    logic        phi2_sync;
    logic        phi2_prev;
    logic        phi2_fall;

    logic [3:0]  cap_a;
    logic        cap_rwb;
    logic        cap_nsel;
    logic [7:0]  cap_din;

    logic        commit;
    logic        commit_wr;
    logic        commit_rd;
    logic        wr_ctrl;
    logic        wr_rel_lo;
    logic        wr_rel_mid;
    logic        wr_rel_hi;
    logic        wr_prescale;
    logic        rd_status;
    logic        rd_count_lo;

    logic        en;
    logic        cont;
    logic        irqen;
    logic        exp_flag;
    logic [23:0] reload;
    logic [23:0] count;
    logic [15:0] snap;
    logic [7:0]  prescale;
    logic [7:0]  pre_cnt;

    logic        tick;
    logic        count_zero;
    logic        expire;
    logic [7:0]  rd_data;

    // ------------------------------------------------------------------
    // Bus sampling and commit strobe
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            phi2_pipe <= 3'b000;
        end else begin
            phi2_pipe <= {phi2_pipe[1:0], PHI2};
        end
    end

    assign phi2_sync = phi2_pipe[1];
    assign phi2_prev = phi2_pipe[2];
    assign phi2_fall = phi2_prev & ~phi2_sync;

    // Keeps the last bus values seen while synchronized PHI2 was high; those
    // are the ones committed on the falling edge.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cap_a    <= 4'd0;
            cap_rwb  <= 1'b1;
            cap_nsel <= 1'b1;
            cap_din  <= 8'd0;
        end else if (phi2_sync) begin
            cap_a    <= A;
            cap_rwb  <= RWB;
            cap_nsel <= nSEL;
            cap_din  <= D_IN;
        end
    end

    assign commit      = phi2_fall & ~cap_nsel;
    assign commit_wr   = commit & ~cap_rwb;
    assign commit_rd   = commit & cap_rwb;

    assign wr_ctrl     = commit_wr && (cap_a == ADDR_CTRL);
    assign wr_rel_lo   = commit_wr && (cap_a == ADDR_REL_LO);
    assign wr_rel_mid  = commit_wr && (cap_a == ADDR_REL_MID);
    assign wr_rel_hi   = commit_wr && (cap_a == ADDR_REL_HI);
    assign wr_prescale = commit_wr && (cap_a == ADDR_PRESCALE);
    assign rd_status   = commit_rd && (cap_a == ADDR_STATUS);
    assign rd_count_lo = commit_rd && (cap_a == ADDR_COUNT_LO);

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    assign tick       = en && (pre_cnt == prescale);
    assign count_zero = (count == 24'd0);
    // A RELOAD_HI commit on the same edge swallows the tick entirely, so
    // neither EXP nor the one-shot EN clear can come from it.
    assign expire     = tick & count_zero & ~wr_rel_hi;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pre_cnt <= 8'd0;
        end else if (!en || wr_rel_hi) begin
            pre_cnt <= 8'd0;
        end else if (pre_cnt == prescale) begin
            pre_cnt <= 8'd0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            count <= 24'd0;
        end else if (wr_rel_hi) begin
            count <= {cap_din, reload[15:0]};
        end else if (tick) begin
            if (!count_zero) begin
                count <= count - 24'd1;
            end else if (cont) begin
                count <= reload;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // A CTRL write on the same edge as an expiry overrides the one-shot EN
    // clear; the expiring tick itself was already decided by the old CONT.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            en    <= 1'b0;
            cont  <= 1'b0;
            irqen <= 1'b0;
        end else if (wr_ctrl) begin
            en    <= cap_din[0];
            cont  <= cap_din[1];
            irqen <= cap_din[2];
        end else if (expire && !cont) begin
            en    <= 1'b0;
        end
    end

    // Expiry outranks the clear-on-read.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (rd_status) begin
            exp_flag <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            reload   <= 24'd0;
            prescale <= 8'd0;
        end else begin
            if (wr_rel_lo) begin
                reload[7:0] <= cap_din;
            end
            if (wr_rel_mid) begin
                reload[15:8] <= cap_din;
            end
            if (wr_rel_hi) begin
                reload[23:16] <= cap_din;
            end
            if (wr_prescale) begin
                prescale <= cap_din;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            snap <= 16'd0;
        end else if (rd_count_lo) begin
            snap <= count[23:8];
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nIRQ <= 1'b1;
        end else begin
            nIRQ <= ~(exp_flag & irqen);
        end
    end

    // ------------------------------------------------------------------
    // Read path (combinational from the raw bus)
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (A)
            ADDR_CTRL:     rd_data = {5'b00000, irqen, cont, en};
            ADDR_STATUS:   rd_data = {6'b000000, en, exp_flag};
            ADDR_REL_LO:   rd_data = reload[7:0];
            ADDR_REL_MID:  rd_data = reload[15:8];
            ADDR_REL_HI:   rd_data = reload[23:16];
            ADDR_COUNT_LO: rd_data = count[7:0];
            ADDR_SNAP_MID: rd_data = snap[7:0];
            ADDR_SNAP_HI:  rd_data = snap[15:8];
            ADDR_PRESCALE: rd_data = prescale;
            default:       rd_data = 8'h00;
        endcase
    end

    assign D_OE  = ~nSEL & RWB & PHI2;
    assign D_OUT = D_OE ? rd_data : 8'h00;

endmodule

// File: tb/tb_jslot_timer.sv
`timescale 1ns/1ps
module tb_jslot_timer;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       PHI2;
    logic       nSEL;
    logic       RWB;
    logic [3:0] A;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       nIRQ;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    jslot_timer dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .PHI2   (PHI2),
        .nSEL   (nSEL),
        .RWB    (RWB),
        .A      (A),
        .D_IN   (D_IN),
        .D_OUT  (D_OUT),
        .D_OE   (D_OE),
        .nIRQ   (nIRQ)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One bus cycle: PHI2 high for 3 CLK, then low with the bus held 4 CLK.
    // fall = CLK count at the PHI2 falling edge; the commit edge is fall+3.
    task automatic bus(input bit sel_n, input bit rw, input logic [3:0] addr,
                       input logic [7:0] wd, output logic [7:0] rd,
                       output logic oe, output int fall);
        @(negedge CLK);
        nSEL = sel_n; RWB = rw; A = addr; D_IN = wd; PHI2 = 1'b1;
        repeat (3) @(negedge CLK);
        rd = D_OUT; oe = D_OE; PHI2 = 1'b0; fall = cyc;
        repeat (4) @(negedge CLK);
        nSEL = 1'b1; RWB = 1'b1; A = 4'd0; D_IN = 8'd0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [7:0] wd, output int fall);
        logic [7:0] d;
        logic o;
        bus(1'b0, 1'b0, addr, wd, d, o, fall);
    endtask

    task automatic rdr(input logic [3:0] addr, output logic [7:0] d);
        logic o;
        int f;
        bus(1'b0, 1'b1, addr, 8'd0, d, o, f);
    endtask

    task automatic wait_nirq(input logic lvl, input int budget, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (nIRQ === lvl) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    // Stop, clear EXP, load PRESCALE and RELOAD (HI also loads COUNT), then CTRL.
    task automatic program_timer(input logic [7:0] p, input logic [23:0] r,
                                 input logic [7:0] c, output int f);
        logic [7:0] d;
        int fx;
        wr(4'd0, 8'h00, fx);
        rdr(4'd1, d);
        wr(4'd8, p, fx);
        wr(4'd2, r[7:0], fx);
        wr(4'd3, r[15:8], fx);
        wr(4'd4, r[23:16], fx);
        wr(4'd0, c, f);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int f;
        bit ok;
        int t;
        n_cmp++;
        if (nIRQ !== 1'b1 || D_OE !== 1'b0 || D_OUT !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: nIRQ=%b D_OE=%b D_OUT=%h required 1 0 00", nIRQ, D_OE, D_OUT);
        end
        nRESET = 1'b1;
        // Continuous with RELOAD=0: EXP on every tick, nIRQ held low.
        program_timer(8'd0, 24'd0, 8'h07, f);
        wait_nirq(1'b0, 20, t, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL reset_precond_irq: nIRQ=%b required 0 before reset", nIRQ);
        end
        // Write PRESCALE but reset before the commit lands.
        @(negedge CLK);
        nSEL = 1'b0; RWB = 1'b0; A = 4'd8; D_IN = 8'h55; PHI2 = 1'b1;
        repeat (3) @(negedge CLK);
        PHI2 = 1'b0;
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        n_cmp++;
        if (nIRQ !== 1'b1) begin
            n_err++;
            $display("FAIL reset_async_irq: nIRQ=%b required 1", nIRQ);
        end
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (3) @(negedge CLK);
        nSEL = 1'b1; RWB = 1'b1; A = 4'd0; D_IN = 8'd0;
        @(negedge CLK);
        n_cmp++;
        if (D_OE !== 1'b0 || D_OUT !== 8'h00 || nIRQ !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: D_OE=%b D_OUT=%h nIRQ=%b required 0 00 1", D_OE, D_OUT, nIRQ);
        end
        for (int i = 0; i < 16; i++) begin
            rdr(4'(i), d);
            n_cmp++;
            if (d !== 8'h00) begin
                n_err++;
                $display("FAIL reset_reg%0d: read %h required 00", i, d);
            end
        end
    endtask

    task automatic test_oneshot();
        int p, r, tt, f, t;
        bit ok;
        logic [7:0] d;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                p = 0; r = 3;
            end else begin
                p = $urandom_range(6, 0); r = $urandom_range(6, 0);
            end
            tt = (r + 1) * (p + 1);
            program_timer(8'(p), 24'(r), 8'h05, f);
            wait_nirq(1'b0, tt + 20, t, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL oneshot_timeout it%0d: nIRQ=%b required 0 within %0d CLK", it, nIRQ, tt + 20);
            end
            n_cmp++;
            if (t != f + 4 + tt && t != f + 5 + tt) begin
                n_err++;
                $display("FAIL oneshot_latency it%0d: nIRQ fell at %0d required %0d or %0d", it, t, f + 4 + tt, f + 5 + tt);
            end
            rdr(4'd1, d);
            n_cmp++;
            if (d !== 8'h01) begin
                n_err++;
                $display("FAIL oneshot_status it%0d: read %h required 01", it, d);
            end
            n_cmp++;
            if (nIRQ !== 1'b1) begin
                n_err++;
                $display("FAIL oneshot_irq_clear it%0d: nIRQ=%b required 1", it, nIRQ);
            end
            rdr(4'd5, d);
            n_cmp++;
            if (d !== 8'h00) begin
                n_err++;
                $display("FAIL oneshot_count it%0d: read %h required 00", it, d);
            end
            repeat (3 * tt + 10) @(negedge CLK);
            n_cmp++;
            if (nIRQ !== 1'b1) begin
                n_err++;
                $display("FAIL oneshot_stays_stopped it%0d: nIRQ=%b required 1", it, nIRQ);
            end
        end
    endtask

    task automatic test_continuous();
        int p, r, tt, f, t1, t2, e1, j, s, fx;
        bit ok;
        logic [7:0] d;
        logic o;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                p = 3; r = 1;
            end else begin
                p = $urandom_range(5, 0); r = $urandom_range(4, 0);
            end
            if ((r + 1) * (p + 1) < 6) p = 5;
            tt = (r + 1) * (p + 1);
            program_timer(8'(p), 24'(r), 8'h07, f);
            wait_nirq(1'b0, tt + 20, t1, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL cont_timeout it%0d: nIRQ=%b required 0 within %0d CLK", it, nIRQ, tt + 20);
            end
            n_cmp++;
            if (t1 != f + 4 + tt && t1 != f + 5 + tt) begin
                n_err++;
                $display("FAIL cont_first it%0d: nIRQ fell at %0d required %0d or %0d", it, t1, f + 4 + tt, f + 5 + tt);
            end
            // Expiry edges are e1 + k*tt; clear 2 CLK after one of them.
            e1 = t1 - 1;
            j  = 1;
            while (e1 + j * tt - 4 < t1 + 1) j++;
            s = e1 + j * tt - 4;
            while (cyc < s - 1) @(negedge CLK);
            bus(1'b0, 1'b1, 4'd1, 8'd0, d, o, fx);
            n_cmp++;
            if (d !== 8'h03) begin
                n_err++;
                $display("FAIL cont_status it%0d: read %h required 03", it, d);
            end
            n_cmp++;
            if (nIRQ !== 1'b1) begin
                n_err++;
                $display("FAIL cont_irq_clear it%0d: nIRQ=%b required 1", it, nIRQ);
            end
            wait_nirq(1'b0, tt + 10, t2, ok);
            n_cmp++;
            if (!ok || t2 != e1 + (j + 1) * tt + 1) begin
                n_err++;
                $display("FAIL cont_period it%0d: nIRQ fell at %0d required %0d", it, t2, e1 + (j + 1) * tt + 1);
            end
        end
    endtask

    task automatic test_collision();
        int p, r, tt, f, t1, e1, n, s, fx;
        bit ok;
        logic [7:0] d;
        logic o;
        p  = $urandom_range(4, 1);
        r  = $urandom_range(3, 1);
        tt = (r + 1) * (p + 1);
        program_timer(8'(p), 24'(r), 8'h07, f);
        wait_nirq(1'b0, tt + 20, t1, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL coll_timeout: nIRQ=%b required 0 within %0d CLK", nIRQ, tt + 20);
        end
        // Land the STATUS read commit exactly on an expiry edge.
        e1 = t1 - 1;
        n  = 1;
        while (e1 + n * tt - 6 < t1 + 1) n++;
        s = e1 + n * tt - 6;
        while (cyc < s - 1) @(negedge CLK);
        bus(1'b0, 1'b1, 4'd1, 8'd0, d, o, fx);
        n_cmp++;
        if (d !== 8'h03) begin
            n_err++;
            $display("FAIL coll_status_data: read %h required 03", d);
        end
        n_cmp++;
        if (nIRQ !== 1'b0) begin
            n_err++;
            $display("FAIL coll_set_wins: nIRQ=%b required 0", nIRQ);
        end
        // Dropping IRQEN releases nIRQ but keeps EXP.
        wr(4'd0, 8'h03, fx);
        n_cmp++;
        if (nIRQ !== 1'b1) begin
            n_err++;
            $display("FAIL irqen_off_irq: nIRQ=%b required 1", nIRQ);
        end
        rdr(4'd1, d);
        n_cmp++;
        if (d !== 8'h03) begin
            n_err++;
            $display("FAIL irqen_off_status: read %h required 03", d);
        end
        wr(4'd0, 8'h00, fx);
    endtask

    task automatic test_snapshot();
        int f;
        logic [7:0] d;
        program_timer(8'd255, 24'h010000, 8'h01, f);
        rdr(4'd5, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++;
            $display("FAIL snap_lo: read %h required 00", d);
        end
        while (cyc < f + 4 + 256 + 8) @(negedge CLK);
        rdr(4'd6, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++;
            $display("FAIL snap_mid: read %h required 00", d);
        end
        rdr(4'd7, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_err++;
            $display("FAIL snap_hi: read %h required 01", d);
        end
        rdr(4'd5, d);
        n_cmp++;
        if (d !== 8'hFF) begin
            n_err++;
            $display("FAIL snap_lo_after_tick: read %h required ff", d);
        end
        rdr(4'd6, d);
        n_cmp++;
        if (d !== 8'hFF) begin
            n_err++;
            $display("FAIL snap_mid_relatch: read %h required ff", d);
        end
        rdr(4'd7, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_err++;
            $display("FAIL snap_hi_relatch: read %h required 00", d);
        end
        wr(4'd0, 8'h00, f);
    endtask

    logic [23:0] um_reload;

    task automatic test_unmapped();
        logic [7:0] model [16];
        logic [7:0] pre, d;
        int f;
        um_reload = 24'($urandom);
        pre = 8'($urandom);
        program_timer(pre, um_reload, 8'h06, f);
        rdr(4'd5, d);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        model[0] = 8'h06;
        model[2] = um_reload[7:0];
        model[3] = um_reload[15:8];
        model[4] = um_reload[23:16];
        model[5] = um_reload[7:0];
        model[6] = um_reload[15:8];
        model[7] = um_reload[23:16];
        model[8] = pre;
        wr(4'd12, 8'($urandom), f);
        wr(4'd1, 8'hFF, f);
        wr(4'd9, 8'($urandom), f);
        wr(4'd15, 8'($urandom), f);
        for (int i = 0; i < 16; i++) begin
            rdr(4'(i), d);
            n_cmp++;
            if (d !== model[i]) begin
                n_err++;
                $display("FAIL unmapped_reg%0d: read %h required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_deselect();
        logic [7:0] d, hi_new;
        logic o;
        int f, t;
        bit ok;
        hi_new = ~um_reload[23:16];
        wr(4'd4, hi_new, f);
        bus(1'b1, 1'b1, 4'd5, 8'd0, d, o, f);
        n_cmp++;
        if (o !== 1'b0 || d !== 8'h00) begin
            n_err++;
            $display("FAIL desel_count_oe: D_OE=%b D_OUT=%h required 0 00", o, d);
        end
        rdr(4'd7, d);
        n_cmp++;
        if (d !== um_reload[23:16]) begin
            n_err++;
            $display("FAIL desel_no_snap: read %h required %h", d, um_reload[23:16]);
        end
        program_timer(8'd0, 24'd0, 8'h05, f);
        wait_nirq(1'b0, 20, t, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL desel_precond_irq: nIRQ=%b required 0", nIRQ);
        end
        bus(1'b1, 1'b1, 4'd1, 8'd0, d, o, f);
        n_cmp++;
        if (o !== 1'b0 || d !== 8'h00) begin
            n_err++;
            $display("FAIL desel_status_oe: D_OE=%b D_OUT=%h required 0 00", o, d);
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (nIRQ !== 1'b0) begin
            n_err++;
            $display("FAIL desel_no_clear: nIRQ=%b required 0", nIRQ);
        end
        rdr(4'd1, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_err++;
            $display("FAIL desel_status_after: read %h required 01", d);
        end
    endtask

    initial begin
        nRESET = 1'b0;
        PHI2   = 1'b0;
        nSEL   = 1'b1;
        RWB    = 1'b1;
        A      = 4'd0;
        D_IN   = 8'd0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_oneshot();
        test_continuous();
        test_collision();
        test_snapshot();
        test_unmapped();
        test_deselect();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
